// File: rtl/ir_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit (master) and memory (slave).
interface ir_fetch_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ir_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC sequencer owning the program counter and the
// instruction register. Optional call/return support with a link register is enabled by
// defining CALL_LINK_EN. DATA_W must be at least OPC_W + ADDR_W.
module ir_fetch_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OPC_W  = 3
) (
  input  logic                clock,
  input  logic                Reset,
  input  logic                start,
  input  logic                halt,
  ir_fetch_unit_if.master     bus,
  output logic [DATA_W-1:0]   ir_q,
  output logic [OPC_W-1:0]    opcode,
  output logic [ADDR_W-1:0]   pc_q,
  output logic                ir_valid,
  input  logic                exec_done,
  input  logic                jmp_take,
`ifdef CALL_LINK_EN
  input  logic                call_take,
  input  logic                ret_take,
  output logic [ADDR_W-1:0]   link_q,
`endif
  input  logic                operand_sel
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] ir_d;
  logic [ADDR_W-1:0] operand;
`ifdef CALL_LINK_EN
  logic [ADDR_W-1:0] link_d;
`endif

  assign operand = ir_q[ADDR_W-1:0];
  assign opcode  = ir_q[DATA_W-1 -: OPC_W];

  // Outputs decoded from the registered state so mem_req never glitches on inputs
  always_comb begin
    bus.mem_req  = (state_q == StFetch);
    ir_valid     = (state_q == StExec);
    bus.mem_addr = pc_q;
    if (state_q == StExec && operand_sel) begin
      bus.mem_addr = operand;
    end
  end

  // Next-state, PC, IR and link computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef CALL_LINK_EN
    link_d  = link_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        // halt is deliberately not looked at here: a started fetch always completes
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
`ifdef CALL_LINK_EN
          if (ret_take) begin
            pc_d = link_q;
          end else if (call_take) begin
            link_d = pc_q;
            pc_d   = operand;
          end else if (jmp_take) begin
            pc_d = operand;
          end
`else
          if (jmp_take) begin
            pc_d = operand;
          end
`endif
          state_d = halt ? StIdle : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset wins over any concurrent ack or exec_done
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
`ifdef CALL_LINK_EN
      link_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef CALL_LINK_EN
      link_q  <= link_d;
`endif
    end
  end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit: directed vector table, hand-written corner
// sequences, then randomized stimulus against a behavioural model.
module tb_ir_fetch_unit;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 3;

  logic          clock = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          exec_done = 1'b0;
  logic          jmp_take = 1'b0;
  logic          operand_sel = 1'b0;
  logic [DW-1:0] ir_q;
  logic [OW-1:0] opcode;
  logic [AW-1:0] pc_q;
  logic          ir_valid;
`ifdef CALL_LINK_EN
  logic          call_take = 1'b0;
  logic          ret_take = 1'b0;
  logic [AW-1:0] link_q;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ir_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ir_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .OPC_W(OW)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .start      (start),
    .halt       (halt),
    .bus        (bus),
    .ir_q       (ir_q),
    .opcode     (opcode),
    .pc_q       (pc_q),
    .ir_valid   (ir_valid),
    .exec_done  (exec_done),
    .jmp_take   (jmp_take),
`ifdef CALL_LINK_EN
    .call_take  (call_take),
    .ret_take   (ret_take),
    .link_q     (link_q),
`endif
    .operand_sel(operand_sel)
  );

  typedef struct {
    logic          rst, st, hl, ack;
    logic [DW-1:0] rdata;
    logic          done, jmp, osel;
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
    logic          valid;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs on the falling edge, then sample one step after the rising edge.
  task automatic cyc(input logic r, input logic s, input logic h, input logic a,
                     input logic [DW-1:0] d, input logic dn, input logic j, input logic o);
    @(negedge clock);
    Reset = r; start = s; halt = h; bus.mem_ack = a; bus.mem_rdata = d;
    exec_done = dn; jmp_take = j; operand_sel = o;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [AW-1:0] addr,
                         input logic [DW-1:0] ir, input logic [AW-1:0] pc, input logic valid);
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(req));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr));
    chk({tag, ".ir_q"}, 32'(ir_q), 32'(ir));
    chk({tag, ".opcode"}, 32'(opcode), 32'(ir >> (DW - OW)));
    chk({tag, ".pc_q"}, 32'(pc_q), 32'(pc));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(valid));
  endtask

  // Behavioural model: mode 0 = idle, 1 = waiting for memory, 2 = executing.
  int          m_mode;
  int unsigned m_pc, m_ir, m_link;

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;

    //          rst   st    hl    ack   rdata  done  jmp   osel  req   addr   ir     pc    valid
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  8'h00, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  8'h00, 5'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  8'h01, 5'd1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  8'h01, 5'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  8'h07, 5'd2, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  8'h07, 5'd2, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  8'h07, 5'd7, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h2F, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  8'h2F, 5'd8, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd15, 8'h2F, 5'd8, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8,  8'h2F, 5'd8, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  8'h2F, 5'd8, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  8'h2F, 5'd8, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  8'h44, 5'd9, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  8'h44, 5'd9, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  8'h44, 5'd9, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00, 5'd0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].hl, vecs[i].ack, vecs[i].rdata,
          vecs[i].done, vecs[i].jmp, vecs[i].osel);
      chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].ir, vecs[i].pc,
              vecs[i].valid);
    end

    // PC wrap: jump to 31, fetch there, expect the counter to roll over to 0.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk_all("wrap_jmp", 1'b1, 5'd31, 8'h1F, 5'd31, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    chk_all("wrap", 1'b0, 5'd0, 8'h03, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Stalled fetch: request and address hold while ack stays low, then reset aborts it.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
      chk_all($sformatf("stall%0d", i), 1'b1, 5'd1, 8'h05, 5'd1, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk_all("stall_rst", 1'b0, 5'd0, 8'h00, 5'd0, 1'b0);

`ifdef CALL_LINK_EN
    // Call/return: pc 4 with ir 0x12 calls to 18, return restores 4 over a jump.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    chk("call_pre_pc", 32'(pc_q), 32'd4);
    @(negedge clock); call_take = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    call_take = 1'b0;
    chk("call_pc", 32'(pc_q), 32'd18);
    chk("call_link", 32'(link_q), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    @(negedge clock); ret_take = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    ret_take = 1'b0;
    chk("ret_pc", 32'(pc_q), 32'd4);
`endif

    // Randomized run against the behavioural model, starting from reset.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    m_mode = 0; m_pc = 0; m_ir = 0; m_link = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, s, h, a, dn, j, o, ct, rt;
      logic [DW-1:0] d;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 1) == 0);
      d  = DW'($urandom);
      dn = ($urandom_range(0, 2) == 0);
      j  = ($urandom_range(0, 1) == 0);
      o  = ($urandom_range(0, 1) == 0);
      ct = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 3) == 0);
`ifdef CALL_LINK_EN
      @(negedge clock); call_take = ct; ret_take = rt;
`else
      ct = 1'b0;
      rt = 1'b0;
`endif
      if (r) begin
        m_mode = 0; m_pc = 0; m_ir = 0; m_link = 0;
      end else if (m_mode == 0) begin
        if (s) m_mode = 1;
      end else if (m_mode == 1) begin
        if (a) begin
          m_ir = d;
          m_pc = (m_pc + 1) % (1 << AW);
          m_mode = 2;
        end
      end else if (dn) begin
        if (rt) m_pc = m_link;
        else if (ct) begin
          m_link = m_pc;
          m_pc = m_ir % (1 << AW);
        end else if (j) m_pc = m_ir % (1 << AW);
        m_mode = h ? 0 : 1;
      end
      cyc(r, s, h, a, d, dn, j, o);
      chk_all($sformatf("rnd%0d", n), (m_mode == 1),
              AW'((m_mode == 2 && o) ? (m_ir % (1 << AW)) : m_pc),
              DW'(m_ir), AW'(m_pc), (m_mode == 2));
`ifdef CALL_LINK_EN
      chk($sformatf("rnd%0d.link", n), 32'(link_q), m_link);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_fetch_unit.md
IR_FETCH_UNIT -- requirements
Module: ir_fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, which sets the instruction and memory data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, which sets the program counter and memory address width.
REQ-003 The block SHALL have parameter OPC_W, default 3, which sets the opcode field width; DATA_W >= OPC_W + ADDR_W SHALL hold.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge; one clock, reset synchronous and active-high.
REQ-005 Reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  leave IDLE and begin fetching.
REQ-007 halt  in  1  return to IDLE at the next instruction boundary.
REQ-008 mem_req  out  1  instruction/operand read request.
REQ-009 mem_addr  out  ADDR_W  memory address.
REQ-010 mem_ack  in  1  read data valid this cycle.
REQ-011 mem_rdata  in  DATA_W  read data.
REQ-012 ir_q  out  DATA_W  instruction register.
REQ-013 opcode  out  OPC_W  ir_q[DATA_W-1 -: OPC_W].
REQ-014 pc_q  out  ADDR_W  program counter.
REQ-015 ir_valid  out  1  ir_q holds a decoded instruction (EXEC state).
REQ-016 exec_done  in  1  controller finished current instruction.
REQ-017 jmp_take  in  1  with exec_done: next PC = operand field ir_q[ADDR_W-1:0].
REQ-018 operand_sel  in  1  in EXEC: mem_addr = operand field instead of pc_q.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH and EXEC, encoded in a registered state variable.
REQ-020 IDLE->FETCH SHALL occur when start=1; start SHALL be ignored outside IDLE.
REQ-021 mem_req SHALL be 1 exactly in FETCH, decoded from the state register, so it rises the cycle after start is sampled.
REQ-022 In FETCH, mem_addr SHALL equal pc_q and SHALL remain stable until mem_ack.
REQ-023 FETCH with mem_ack=1 SHALL load ir_q<=mem_rdata, set pc_q<=pc_q+1 modulo 2^ADDR_W, and go to EXEC; ir_valid SHALL be 1 the following cycle.
REQ-024 FETCH with mem_ack=0 SHALL hold all state; mem_ack outside FETCH SHALL be ignored.
REQ-025 In EXEC, mem_addr SHALL equal ir_q[ADDR_W-1:0] when operand_sel=1, and pc_q otherwise.
REQ-026 EXEC with exec_done=1 SHALL load pc_q<=ir_q[ADDR_W-1:0] if jmp_take=1, and SHALL leave pc_q unchanged otherwise.
REQ-027 EXEC with exec_done=1 SHALL go to IDLE if halt=1, and to FETCH otherwise; jmp_take without exec_done SHALL be ignored.
REQ-028 halt asserted in FETCH SHALL NOT abort the fetch; the block SHALL complete it and return to IDLE at the next exec_done while halt is still 1.
REQ-029 pc_q wrap-around SHALL be silent: 2^ADDR_W-1 increments to 0.
REQ-030 ir_q SHALL change only on an accepted fetch.

Reset
REQ-031 Reset=1 SHALL force state=IDLE, pc_q=0, ir_q=0, mem_req=0, ir_valid=0 and mem_addr=0 on the next edge, with priority over all other inputs.
REQ-032 Reset in FETCH SHALL abort the request: mem_req=0 the cycle after reset is sampled, and a concurrent mem_ack SHALL be discarded.

Configuration
REQ-033 With macro CALL_LINK_EN defined, the block SHALL add inputs call_take and ret_take and an ADDR_W-bit link register (reset 0).
REQ-034 Under CALL_LINK_EN, exec_done with call_take SHALL set link<=pc_q and pc_q<=operand field; exec_done with ret_take SHALL set pc_q<=link; priority SHALL be ret_take > call_take > jmp_take.
REQ-035 Without CALL_LINK_EN, those ports and the link register SHALL be absent, and behaviour SHALL be exactly REQ-019..REQ-032.

Verification
REQ-036 Reset, then start; mem_ack with mem_rdata=8'h01 two cycles later -> ir_q=8'h01, opcode=0, pc_q=1, ir_valid=1 the next cycle.
REQ-037 In EXEC with ir_q=8'h07, pulse exec_done+jmp_take -> pc_q=7, FETCH, mem_addr=7.
REQ-038 With pc_q=31 (ADDR_W=5), complete a fetch -> pc_q=0.
REQ-039 Hold mem_ack=0 for 5 cycles -> mem_req=1 and mem_addr constant throughout; assert Reset during the wait -> IDLE, mem_req=0, pc_q=0.
REQ-040 With ir_q=8'h2F and operand_sel=1 in EXEC -> mem_addr=15; then exec_done+halt -> IDLE, mem_req=0.
REQ-041 With CALL_LINK_EN and pc_q=4, ir_q=8'h12: exec_done+call_take -> pc_q=18, link=4; later exec_done+ret_take+jmp_take -> pc_q=4.
